// File: rtl/audio_mixer_seq_if.sv
// Bus between the tone generators / codec path and audio_mixer_seq.
// Optional master volume port appears when MIXER_VOLUME_EN is defined.
interface audio_mixer_seq_if #(
  parameter int NUM_CH = 9,
  parameter int IN_W   = 10,
  parameter int OUT_W  = 32
);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  // Handshake: sample_tick is a one-cycle request with no ready; it is taken
  // only while busy is low, otherwise it is dropped and latches overrun.
  // mix_valid is a one-cycle pulse qualifying mixed_audio/active_count,
  // which then hold until the next pulse.
  logic                     sample_tick;
  logic [NUM_CH*IN_W-1:0]   ch_data;
  logic [NUM_CH-1:0]        ch_en;
`ifdef MIXER_VOLUME_EN
  logic [2:0]               volume;
`endif
  logic [OUT_W-1:0]         mixed_audio;
  logic                     mix_valid;
  logic                     busy;
  logic [CNT_W-1:0]         active_count;
  logic                     overrun;
  logic [1:0]               state_dbg;

  modport master (
    output sample_tick, ch_data, ch_en,
`ifdef MIXER_VOLUME_EN
    output volume,
`endif
    input  mixed_audio, mix_valid, busy, active_count, overrun, state_dbg
  );

  modport slave (
    input  sample_tick, ch_data, ch_en,
`ifdef MIXER_VOLUME_EN
    input  volume,
`endif
    output mixed_audio, mix_valid, busy, active_count, overrun, state_dbg
  );
endinterface

// File: rtl/audio_mixer_seq.sv
// Serial voice mixer: snapshot on sample_tick, accumulate one voice per clock,
// divide by a power of two covering the active count. Optional: MIXER_VOLUME_EN.
module audio_mixer_seq #(
  parameter int NUM_CH = 9,
  parameter int IN_W   = 10,
  parameter int OUT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  audio_mixer_seq_if.slave   bus
);
  localparam int AW    = IN_W + $clog2(NUM_CH);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NUM_CH*IN_W-1:0]  snap_data;
  logic [NUM_CH-1:0]       snap_en;
  logic [IDX_W-1:0]        idx;
  logic signed [AW-1:0]    acc;
  logic [CNT_W-1:0]        cnt;
  logic [IN_W-1:0]         cur_sample;
  logic [3:0]              shift_amt;
  logic [IN_W-1:0]         q;
  logic [OUT_W-1:0]        mixed_audio_r;
  logic [CNT_W-1:0]        active_count_r;
  logic                    mix_valid_r;
  logic                    overrun_r;
`ifdef MIXER_VOLUME_EN
  logic [2:0]              snap_vol;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sample_tick) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_nxt = SCALE;
      SCALE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cur_sample = snap_data[int'(idx)*IN_W +: IN_W];

  // ceil(log2(cnt)), with 0 and 1 voices both mapping to no shift
  always_comb begin
    shift_amt = '0;
    for (int i = 0; i < 4; i++) begin
      if (int'(cnt) > (1 << i)) shift_amt = 4'(i + 1);
    end
`ifdef MIXER_VOLUME_EN
    shift_amt = shift_amt + {1'b0, snap_vol};
`endif
    q = IN_W'(acc >>> shift_amt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_data      <= '0;
      snap_en        <= '0;
      idx            <= '0;
      acc            <= '0;
      cnt            <= '0;
      mixed_audio_r  <= '0;
      active_count_r <= '0;
      mix_valid_r    <= 1'b0;
      overrun_r      <= 1'b0;
`ifdef MIXER_VOLUME_EN
      snap_vol       <= '0;
`endif
    end else begin
      mix_valid_r <= 1'b0;
      if (bus.sample_tick && state != IDLE) overrun_r <= 1'b1;
      case (state)
        IDLE: if (bus.sample_tick) begin
          snap_data <= bus.ch_data;
          snap_en   <= bus.ch_en;
          acc       <= '0;
          cnt       <= '0;
          idx       <= '0;
`ifdef MIXER_VOLUME_EN
          snap_vol  <= bus.volume;
`endif
        end
        ACCUM: begin
          // Silent voices are skipped so they do not dilute the average
          if (snap_en[idx] && cur_sample != '0) begin
            acc <= acc + AW'($signed(cur_sample));
            cnt <= cnt + 1'b1;
          end
          idx <= idx + 1'b1;
        end
        SCALE: begin
          mixed_audio_r  <= OUT_W'(q) << (OUT_W - IN_W);
          active_count_r <= cnt;
          mix_valid_r    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mixed_audio  = mixed_audio_r;
  assign bus.active_count = active_count_r;
  assign bus.mix_valid    = mix_valid_r;
  assign bus.overrun      = overrun_r;
  assign bus.busy         = (state != IDLE);
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_audio_mixer_seq.sv
// Directed bench for audio_mixer_seq: hand-computed mixes, latency, masking,
// overrun, back-to-back ticks and mid-mix reset.
module tb_audio_mixer_seq;
  localparam int NUM_CH = 9;
  localparam int IN_W   = 10;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = $clog2(NUM_CH + 1);

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [OUT_W-1:0] exp_q[$];

  audio_mixer_seq_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  audio_mixer_seq #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.sample_tick = 1'b0;
    bus.ch_data     = '0;
    bus.ch_en       = '0;
`ifdef MIXER_VOLUME_EN
    bus.volume      = 3'd0;
`endif
  endtask

  task automatic set_ch(input int k, input int val);
    logic [31:0] v;
    v = val;
    bus.ch_data[k*IN_W +: IN_W] = v[IN_W-1:0];
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one tick, scrambles inputs after the snapshot, waits for mix_valid
  // and checks latency, result, active_count, then busy release and hold.
  task automatic run_mix(input string name, input logic [OUT_W-1:0] exp_audio,
                         input logic [CNT_W-1:0] exp_cnt);
    int edges;
    logic [OUT_W-1:0] e;
    exp_q.push_back(exp_audio);
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    bus.ch_data = {NUM_CH{10'h155}};
    bus.ch_en   = '1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_tick: got %b want 1", name, bus.busy);
    end
    edges = 0;
    while (bus.mix_valid !== 1'b1 && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    // tick cycle is T, so mix_valid at T+NUM_CH+2 is NUM_CH+1 edges later
    checks++;
    if (edges !== NUM_CH + 1) begin
      errors++; $display("FAIL %s latency: got %0d edges want %0d", name, edges, NUM_CH + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.mixed_audio !== e) begin
      errors++; $display("FAIL %s mixed_audio: got %h want %h", name, bus.mixed_audio, e);
    end
    checks++;
    if (bus.active_count !== exp_cnt) begin
      errors++; $display("FAIL %s active_count: got %0d want %0d", name, bus.active_count, exp_cnt);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.mix_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mixed_audio !== e) begin
      errors++;
      $display("FAIL %s hold: valid=%b busy=%b audio=%h want 0 0 %h",
               name, bus.mix_valid, bus.busy, bus.mixed_audio, e);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.mixed_audio !== '0 || bus.mix_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.active_count !== '0 || bus.overrun !== 1'b0 || bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: audio=%h valid=%b busy=%b cnt=%0d ovr=%b st=%0d want all 0",
               bus.mixed_audio, bus.mix_valid, bus.busy, bus.active_count, bus.overrun, bus.state_dbg);
    end
  endtask

  task automatic test_single();
    set_ch(0, 100); bus.ch_en = 9'b000000001;
    run_mix("single", 32'h1900_0000, 4'd1);
  endtask

  task automatic test_three();
    set_ch(0, 300); set_ch(1, 300); set_ch(2, -100);
    bus.ch_en = 9'b000000111;
    run_mix("three", 32'h1F40_0000, 4'd3);
  endtask

  task automatic test_full_scale();
    for (int k = 0; k < NUM_CH; k++) set_ch(k, -512);
    bus.ch_en = '1;
    run_mix("full_neg", 32'hB800_0000, 4'd9);
  endtask

  task automatic test_masking();
    set_ch(0, -3); set_ch(1, 2); set_ch(5, 400);
    bus.ch_en = 9'b000000011;
    run_mix("floor_mask", 32'hFFC0_0000, 4'd2);
    // enabled zero voice is not counted, so no halving
    set_ch(0, 0); set_ch(3, 100);
    bus.ch_en = 9'b000001001;
    run_mix("zero_voice", 32'h1900_0000, 4'd1);
  endtask

  task automatic test_back_to_back();
    int edges;
    set_ch(0, 100); bus.ch_en = 9'b000000001;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    edges = 0;
    while (bus.mix_valid !== 1'b1 && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    @(posedge clk); #1;          // IDLE cycle right after DONE
    set_ch(0, 300); set_ch(1, 300); set_ch(2, -100);
    bus.ch_en = 9'b000000111;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    edges = 0;
    while (bus.mix_valid !== 1'b1 && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
    checks++;
    if (edges !== NUM_CH + 1 || bus.mixed_audio !== 32'h1F40_0000) begin
      errors++;
      $display("FAIL back_to_back: edges=%0d audio=%h want %0d 1f400000", edges, bus.mixed_audio, NUM_CH + 1);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL back_to_back_overrun: got %b want 0", bus.overrun);
    end
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_overrun();
    int pulses;
    int edges;
    logic [CNT_W-1:0] cnt_seen;
    logic [OUT_W-1:0] audio_seen;
    bus.ch_en = '1;                 // all voices enabled but silent
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    pulses = 0;
    audio_seen = '1;
    cnt_seen = '1;
    edges = 1;
    while (edges < 30) begin
      bus.sample_tick = (edges == 4);
      @(posedge clk); #1;
      edges++;
      if (bus.mix_valid === 1'b1) begin
        pulses++;
        audio_seen = bus.mixed_audio;
        cnt_seen = bus.active_count;
      end
    end
    bus.sample_tick = 1'b0;
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (audio_seen !== '0 || cnt_seen !== '0) begin
      errors++; $display("FAIL silent_mix: audio=%h cnt=%0d want 0 0", audio_seen, cnt_seen);
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b want 1", bus.overrun);
    end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    int pulses;
    set_ch(0, 100); bus.ch_en = 9'b000000001;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mix_valid !== 1'b0 || bus.mixed_audio !== '0 ||
        bus.active_count !== '0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b audio=%h cnt=%0d ovr=%b want all 0",
               bus.busy, bus.mix_valid, bus.mixed_audio, bus.active_count, bus.overrun);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.mix_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL no_valid_after_reset: got %0d pulses want 0", pulses);
    end
    run_mix("after_reset", 32'h1900_0000, 4'd1);
  endtask

`ifdef MIXER_VOLUME_EN
  task automatic test_volume();
    set_ch(0, 100); bus.ch_en = 9'b000000001;
    bus.volume = 3'd1;
    run_mix("volume1", 32'h0C80_0000, 4'd1);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_three();
    test_full_scale();
    test_masking();
    test_back_to_back();
    test_overrun();
    test_mid_reset();
`ifdef MIXER_VOLUME_EN
    test_volume();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
